// File: rtl/alu_pkg.sv
// Shared opcode and FSM state types for the sequential ALU (alu_seq).
package alu_pkg;

    localparam int ALU_OP_W = 3;

    typedef enum logic [ALU_OP_W-1:0] {
        OP_XOR         = 3'b001,
        OP_NE          = 3'b010,
        OP_ADD         = 3'b011,
        OP_SHL         = 3'b100,
        OP_SHR         = 3'b101,
        OP_PASSB       = 3'b110,
        OP_PASSA       = 3'b111,
        OP_ZERO_OR_ROL = 3'b000
    } alu_op_t;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'b00,
        ST_SHIFT = 2'b01,
        ST_DONE  = 2'b10
    } alu_state_t;

endpackage

// File: rtl/alu_comb_core.sv
// Single-cycle ALU operations (logic, compare, add with carry); shifts are not handled here.
module alu_comb_core
    import alu_pkg::*;
#(
    parameter int W = 8
) (
    input  alu_op_t        op,
    input  logic [W-1:0]   a,
    input  logic [W-1:0]   b,
    input  logic           ci,
    output logic [W-1:0]   rslt,
    output logic           co
);

    logic [W:0] sum_s;

    assign sum_s = {1'b0, a} + {1'b0, b} + {{W{1'b0}}, ci};

    // Opcode decode for the one-cycle operations; anything else yields zero
    always_comb begin
        rslt = {W{1'b0}};
        co   = 1'b0;
        case (op)
            OP_XOR:   rslt = a ^ b;
            OP_NE:    rslt = {{(W-1){1'b0}}, (a != b)};
            OP_ADD: begin
                rslt = sum_s[W-1:0];
                co   = sum_s[W];
            end
            OP_PASSB: rslt = b;
            OP_PASSA: rslt = a;
            default:  rslt = {W{1'b0}};
        endcase
    end

endmodule

// File: rtl/alu_seq.sv
// Handshaked sequential ALU: one-cycle logic/add ops, 1-bit/cycle shifts.
// Optional ALU_ROTATE_EN turns opcode 000 into an iterative rotate-left.
module alu_seq
    import alu_pkg::*;
#(
    parameter int W  = 8,
    parameter int A  = 3,
    parameter int SW = $clog2(W) + 1
) (
    input  logic           clk,
    input  logic           reset,
    input  logic           in_valid,
    output logic           in_ready,
    input  logic [A-1:0]   alu_cmd,
    input  logic [W-1:0]   inA,
    input  logic [W-1:0]   inB,
    input  logic           sc_i,
    output logic           out_valid,
    input  logic           out_ready,
    output logic [W-1:0]   rslt,
    output logic           sc_o,
    output logic           pari,
    output logic           zero,
    output logic           busy
);

    localparam logic [W-1:0]  W_VAL = W'(W);
    localparam logic [SW-1:0] W_CNT = SW'(W);

    function automatic logic parity_f(input logic [W-1:0] v);
        return ^v;
    endfunction

    alu_state_t     state_r, state_nx_s;
    alu_op_t        sh_op_r, sh_op_nx_s;
    logic [W-1:0]   rslt_r, rslt_nx_s;
    logic           sc_r, sc_nx_s;
    logic [SW-1:0]  cnt_r, cnt_nx_s;

    alu_op_t        op_s;
    logic           accept_s;
    logic           is_shift_s;
    logic [SW-1:0]  shamt_s;
    logic [W-1:0]   core_rslt_s;
    logic           core_co_s;

    assign op_s     = alu_op_t'(alu_cmd[ALU_OP_W-1:0]);
    assign accept_s = in_valid & in_ready;

    alu_comb_core #(.W(W)) u_core (
        .op   (op_s),
        .a    (inA),
        .b    (inB),
        .ci   (sc_i),
        .rslt (core_rslt_s),
        .co   (core_co_s)
    );

    // Classify the offered op and derive its iteration count (saturated at W)
    always_comb begin
        is_shift_s = 1'b0;
        shamt_s    = {SW{1'b0}};
        case (op_s)
            OP_SHL, OP_SHR: begin
                is_shift_s = 1'b1;
                shamt_s    = (inA >= W_VAL) ? W_CNT : inA[SW-1:0];
            end
`ifdef ALU_ROTATE_EN
            OP_ZERO_OR_ROL: begin
                is_shift_s = 1'b1;
                shamt_s    = SW'(inA % W_VAL);
            end
`endif
            default: begin
                is_shift_s = 1'b0;
                shamt_s    = {SW{1'b0}};
            end
        endcase
    end

    // Input handshake: DONE frees up only as the consumer drains the result
    always_comb begin
        in_ready = 1'b0;
        case (state_r)
            ST_IDLE: in_ready = 1'b1;
            ST_DONE: in_ready = out_ready;
            default: in_ready = 1'b0;
        endcase
    end

    // Next-state and datapath update; rslt_r doubles as the shift register
    always_comb begin
        state_nx_s = state_r;
        sh_op_nx_s = sh_op_r;
        rslt_nx_s  = rslt_r;
        sc_nx_s    = sc_r;
        cnt_nx_s   = cnt_r;
        if (accept_s) begin
            if (is_shift_s) begin
                rslt_nx_s  = inB;
                sc_nx_s    = 1'b0;
                cnt_nx_s   = shamt_s;
                sh_op_nx_s = op_s;
                state_nx_s = (shamt_s == {SW{1'b0}}) ? ST_DONE : ST_SHIFT;
            end else begin
                rslt_nx_s  = core_rslt_s;
                sc_nx_s    = core_co_s;
                cnt_nx_s   = {SW{1'b0}};
                state_nx_s = ST_DONE;
            end
        end else if (state_r == ST_SHIFT) begin
            cnt_nx_s = cnt_r - SW'(1);
            case (sh_op_r)
                OP_SHL: begin
                    rslt_nx_s = {rslt_r[W-2:0], 1'b0};
                    sc_nx_s   = rslt_r[W-1];
                end
                OP_SHR: begin
                    rslt_nx_s = {1'b0, rslt_r[W-1:1]};
                    sc_nx_s   = rslt_r[0];
                end
`ifdef ALU_ROTATE_EN
                OP_ZERO_OR_ROL: begin
                    rslt_nx_s = {rslt_r[W-2:0], rslt_r[W-1]};
                    sc_nx_s   = rslt_r[W-1];
                end
`endif
                default: begin
                    rslt_nx_s = rslt_r;
                    sc_nx_s   = sc_r;
                end
            endcase
            if (cnt_r == SW'(1)) begin
                state_nx_s = ST_DONE;
            end else begin
                state_nx_s = ST_SHIFT;
            end
        end else if ((state_r == ST_DONE) && out_ready) begin
            state_nx_s = ST_IDLE;
        end else begin
            state_nx_s = state_r;
        end
    end

    // State and result registers with synchronous reset
    always_ff @(posedge clk) begin
        if (reset) begin
            state_r <= ST_IDLE;
            sh_op_r <= OP_ZERO_OR_ROL;
            rslt_r  <= {W{1'b0}};
            sc_r    <= 1'b0;
            cnt_r   <= {SW{1'b0}};
        end else begin
            state_r <= state_nx_s;
            sh_op_r <= sh_op_nx_s;
            rslt_r  <= rslt_nx_s;
            sc_r    <= sc_nx_s;
            cnt_r   <= cnt_nx_s;
        end
    end

    assign rslt      = rslt_r;
    assign sc_o      = sc_r;
    assign pari      = parity_f(rslt_r);
    assign zero      = (rslt_r == {W{1'b0}});
    assign out_valid = (state_r == ST_DONE);
    assign busy      = (state_r != ST_IDLE);

endmodule

// File: tb/tb_alu_seq.sv
// Self-checking bench for alu_seq (W=8): directed vectors plus randomized ops vs a behavioural model.
module tb_alu_seq;

    localparam int W = 8;

    logic       clk = 1'b0;
    logic       reset;
    logic       in_valid;
    logic       in_ready;
    logic [2:0] alu_cmd;
    logic [7:0] inA;
    logic [7:0] inB;
    logic       sc_i;
    logic       out_valid;
    logic       out_ready;
    logic [7:0] rslt;
    logic       sc_o;
    logic       pari;
    logic       zero;
    logic       busy;

    int checks = 0;
    int errors = 0;

    alu_seq #(.W(W), .A(3)) dut (
        .clk       (clk),
        .reset     (reset),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .alu_cmd   (alu_cmd),
        .inA       (inA),
        .inB       (inB),
        .sc_i      (sc_i),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .rslt      (rslt),
        .sc_o      (sc_o),
        .pari      (pari),
        .zero      (zero),
        .busy      (busy)
    );

    always #5 clk = ~clk;

    // Behavioural reference: result, flag and accept-to-out_valid latency in cycles
    function automatic void ref_model(input logic [2:0] op, input logic [7:0] a, input logic [7:0] b,
                                      input logic ci, output logic [7:0] r, output logic c, output int lat);
        int n;
        int full;
        int tmp;
        r = 8'h00; c = 1'b0; lat = 1;
        case (op)
            3'd1: r = a ^ b;
            3'd2: r = (a != b) ? 8'd1 : 8'd0;
            3'd3: begin
                full = int'(a) + int'(b) + int'(ci);
                r = full[7:0];
                c = full[8];
            end
            3'd4: begin
                n = (int'(a) > W) ? W : int'(a);
                tmp = int'(b) << n;
                r = tmp[7:0];
                tmp = (n > 0) ? (int'(b) >> (W - n)) : 0;
                c = tmp[0];
                lat = n + 1;
            end
            3'd5: begin
                n = (int'(a) > W) ? W : int'(a);
                tmp = int'(b) >> n;
                r = tmp[7:0];
                tmp = (n > 0) ? (int'(b) >> (n - 1)) : 0;
                c = tmp[0];
                lat = n + 1;
            end
            3'd6: r = b;
            3'd7: r = a;
            default: begin
`ifdef ALU_ROTATE_EN
                n = int'(a) % W;
                tmp = (n > 0) ? ((int'(b) << n) | (int'(b) >> (W - n))) : int'(b);
                r = tmp[7:0];
                c = (n > 0) ? r[0] : 1'b0;
                lat = n + 1;
`else
                r = 8'h00;
`endif
            end
        endcase
    endfunction

    // Drive one op with out_ready=1 and collect the registered result and timing
    task automatic run_op(input logic [2:0] op, input logic [7:0] a, input logic [7:0] b, input logic ci,
                          output logic [7:0] r, output logic c, output logic p, output logic z,
                          output int lat, output int low_cnt, output bit ok);
        int guard;
        @(negedge clk);
        out_ready = 1'b1; alu_cmd = op; inA = a; inB = b; sc_i = ci; in_valid = 1'b1;
        #1;
        guard = 0;
        while (!in_ready && guard < 50) begin
            @(negedge clk);
            guard++;
        end
        @(posedge clk);
        #1;
        in_valid = 1'b0; inA = ~a; inB = ~b; sc_i = ~ci;
        lat = 1; low_cnt = 0;
        @(negedge clk);
        while (!out_valid && lat < 50) begin
            if (!in_ready) low_cnt++;
            @(negedge clk);
            lat++;
        end
        r = rslt; c = sc_o; p = pari; z = zero;
        ok = out_valid && (guard < 50);
    endtask

    task automatic test_reset();
        reset = 1'b1; in_valid = 1'b0; out_ready = 1'b0; alu_cmd = 3'd0; inA = 8'h00; inB = 8'h00; sc_i = 1'b0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        reset = 1'b0;
        #1;
        checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL reset_out_valid got %b want 0", out_valid); end
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL reset_busy got %b want 0", busy); end
        checks++; if (rslt !== 8'h00) begin errors++; $display("FAIL reset_rslt got %h want 00", rslt); end
        checks++; if (sc_o !== 1'b0 || pari !== 1'b0 || zero !== 1'b1) begin
            errors++; $display("FAIL reset_flags got sc=%b pari=%b zero=%b want 0 0 1", sc_o, pari, zero); end
        checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL reset_in_ready got %b want 1", in_ready); end
    endtask

    task automatic test_add();
        logic [7:0] r; logic c, p, z; int lat, low; bit ok;
        run_op(3'b011, 8'hF0, 8'h20, 1'b1, r, c, p, z, lat, low, ok);
        checks++; if (!ok) begin errors++; $display("FAIL add_timeout got no out_valid want out_valid"); end
        checks++; if (r !== 8'h11 || c !== 1'b1) begin errors++; $display("FAIL add_result got %h/%b want 11/1", r, c); end
        checks++; if (p !== 1'b0 || z !== 1'b0) begin errors++; $display("FAIL add_flags got pari=%b zero=%b want 0 0", p, z); end
        checks++; if (lat !== 1) begin errors++; $display("FAIL add_latency got %0d want 1", lat); end
    endtask

    task automatic test_shift();
        logic [7:0] r; logic c, p, z; int lat, low; bit ok;
        run_op(3'b100, 8'd3, 8'b1010_0001, 1'b0, r, c, p, z, lat, low, ok);
        checks++; if (!ok || r !== 8'h08 || c !== 1'b1) begin errors++; $display("FAIL shl3_result got %h/%b want 08/1", r, c); end
        checks++; if (lat !== 4) begin errors++; $display("FAIL shl3_latency got %0d want 4", lat); end
        checks++; if (low !== 3) begin errors++; $display("FAIL shl3_in_ready_low got %0d want 3", low); end
        run_op(3'b101, 8'd9, 8'hFF, 1'b0, r, c, p, z, lat, low, ok);
        checks++; if (!ok || r !== 8'h00 || z !== 1'b1 || c !== 1'b1) begin
            errors++; $display("FAIL shr9_result got %h/%b zero=%b want 00/1 zero=1", r, c, z); end
        checks++; if (lat !== 9) begin errors++; $display("FAIL shr9_latency got %0d want 9", lat); end
        run_op(3'b101, 8'd0, 8'h5A, 1'b1, r, c, p, z, lat, low, ok);
        checks++; if (!ok || r !== 8'h5A || c !== 1'b0 || lat !== 1) begin
            errors++; $display("FAIL shr0 got %h/%b lat=%0d want 5a/0 lat=1", r, c, lat); end
        run_op(3'b100, 8'd8, 8'h01, 1'b0, r, c, p, z, lat, low, ok);
        checks++; if (!ok || r !== 8'h00 || c !== 1'b1 || lat !== 9) begin
            errors++; $display("FAIL shl8 got %h/%b lat=%0d want 00/1 lat=9", r, c, lat); end
    endtask

    task automatic test_backpressure();
        @(negedge clk);
        out_ready = 1'b0; alu_cmd = 3'b001; inA = 8'h0F; inB = 8'hFF; sc_i = 1'b0; in_valid = 1'b1;
        @(posedge clk);
        #1;
        alu_cmd = 3'b111; inA = 8'h33; inB = 8'h44; in_valid = 1'b1;
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            checks++; if (out_valid !== 1'b1 || rslt !== 8'hF0) begin
                errors++; $display("FAIL bp_hold[%0d] got valid=%b rslt=%h want 1 f0", i, out_valid, rslt); end
            checks++; if (in_ready !== 1'b0) begin errors++; $display("FAIL bp_in_ready[%0d] got %b want 0", i, in_ready); end
        end
        @(negedge clk);
        out_ready = 1'b1;
        #1;
        checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL bp_release_in_ready got %b want 1", in_ready); end
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        @(negedge clk);
        checks++; if (out_valid !== 1'b1 || rslt !== 8'h33 || sc_o !== 1'b0) begin
            errors++; $display("FAIL bp_next_op got valid=%b rslt=%h sc=%b want 1 33 0", out_valid, rslt, sc_o); end
        @(negedge clk);
        checks++; if (out_valid !== 1'b0 || busy !== 1'b0) begin
            errors++; $display("FAIL bp_drain got valid=%b busy=%b want 0 0", out_valid, busy); end
    endtask

    task automatic test_back_to_back();
        @(negedge clk);
        out_ready = 1'b1; alu_cmd = 3'b111; inA = 8'd1; inB = 8'h00; in_valid = 1'b1;
        for (int k = 1; k <= 4; k++) begin
            @(negedge clk);
            checks++; if (out_valid !== 1'b1 || rslt !== 8'(k)) begin
                errors++; $display("FAIL stream[%0d] got valid=%b rslt=%h want 1 %h", k, out_valid, rslt, 8'(k)); end
            if (k < 4) inA = 8'(k + 1);
            else in_valid = 1'b0;
        end
        @(negedge clk);
        checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL stream_end got valid=%b want 0", out_valid); end
    endtask

    task automatic test_reset_mid_shift();
        @(negedge clk);
        out_ready = 1'b1; alu_cmd = 3'b100; inA = 8'd5; inB = 8'hC3; in_valid = 1'b1;
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        @(negedge clk);
        checks++; if (busy !== 1'b1 || out_valid !== 1'b0) begin
            errors++; $display("FAIL midshift_busy got busy=%b valid=%b want 1 0", busy, out_valid); end
        @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
        checks++; if (out_valid !== 1'b0 || busy !== 1'b0 || rslt !== 8'h00 || zero !== 1'b1 || sc_o !== 1'b0) begin
            errors++; $display("FAIL midshift_reset got valid=%b busy=%b rslt=%h zero=%b sc=%b want 0 0 00 1 0",
                               out_valid, busy, rslt, zero, sc_o); end
        reset = 1'b0;
    endtask

    task automatic test_rotate_opcode();
        logic [7:0] r; logic c, p, z; int lat, low; bit ok;
        run_op(3'b000, 8'd10, 8'h81, 1'b1, r, c, p, z, lat, low, ok);
`ifdef ALU_ROTATE_EN
        checks++; if (!ok || r !== 8'h06 || c !== 1'b0 || lat !== 3) begin
            errors++; $display("FAIL rol10 got %h/%b lat=%0d want 06/0 lat=3", r, c, lat); end
`else
        checks++; if (!ok || r !== 8'h00 || c !== 1'b0 || lat !== 1) begin
            errors++; $display("FAIL op000 got %h/%b lat=%0d want 00/0 lat=1", r, c, lat); end
`endif
    endtask

    task automatic test_random();
        logic [2:0] op; logic [7:0] a, b; logic ci;
        logic [7:0] er, r; logic ec, c, p, z; int elat, lat, low; bit ok;
        for (int k = 0; k < 120; k++) begin
            op = 3'($urandom_range(0, 7));
            a  = ($urandom_range(0, 1) == 0) ? 8'($urandom_range(0, 10)) : 8'($urandom_range(0, 255));
            b  = 8'($urandom_range(0, 255));
            ci = 1'($urandom_range(0, 1));
            ref_model(op, a, b, ci, er, ec, elat);
            run_op(op, a, b, ci, r, c, p, z, lat, low, ok);
            checks++; if (!ok || r !== er || c !== ec) begin
                errors++; $display("FAIL rand[%0d] op=%0d a=%h b=%h ci=%b got %h/%b want %h/%b", k, op, a, b, ci, r, c, er, ec); end
            checks++; if (p !== (^er) || z !== (er == 8'h00)) begin
                errors++; $display("FAIL rand_flags[%0d] got pari=%b zero=%b want %b %b", k, p, z, ^er, er == 8'h00); end
            checks++; if (lat !== elat) begin
                errors++; $display("FAIL rand_lat[%0d] op=%0d a=%h got %0d want %0d", k, op, a, lat, elat); end
        end
    endtask

    initial begin
        test_reset();
        test_add();
        test_shift();
        test_backpressure();
        test_back_to_back();
        test_reset_mid_shift();
        test_rotate_opcode();
        test_random();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
